spdif_tx_clk_switch: RTL and testbench



---
 rtl/spdif_pkg.sv | 17 +
 rtl/spdif_sw_timer.sv | 33 +++
 rtl/spdif_tx_clk_switch.sv | 139 +++++++++++++
 tb/tb_spdif_tx_clk_switch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared rate encodings, FSM states and default timing for the S/PDIF TX clock switch
package spdif_pkg;

  localparam logic RATE_44K1 = 1'b0;
  localparam logic RATE_48K  = 1'b1;

  localparam int DEF_SETTLE_CYCLES = 256;
  localparam int DEF_DRAIN_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } spdif_sw_state_e;

endpackage

// File: rtl/spdif_sw_timer.sv
// rtl/spdif_sw_timer.sv - loadable saturating down-counter with a registered zero flag
module spdif_sw_timer #(
  parameter int                 TIMER_W = 16,
  parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_zero
);

  logic [TIMER_W-1:0] count_q;
  logic               zero_q;

  // zero_q always mirrors (count_q == 0) so the FSM sees it without a compare path
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= RST_VAL;
      zero_q  <= (RST_VAL == '0);
    end else if (i_load) begin
      count_q <= i_load_val;
      zero_q  <= (i_load_val == '0);
    end else if (i_en && (count_q != '0)) begin
      count_q <= count_q - TIMER_W'(1);
      zero_q  <= (count_q == TIMER_W'(1));
    end
  end

  assign o_zero = zero_q;

endmodule

// File: rtl/spdif_tx_clk_switch.sv
// rtl/spdif_tx_clk_switch.sv - glitch-safe S/PDIF TX clock-mux select sequencer (hold, drain, switch, settle).
// Optional SPDIF_CLK_SWITCH_STATS_EN adds a saturating o_switch_count.
module spdif_tx_clk_switch
  import spdif_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int TIMER_W       = 16
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_rate_req,
  input  logic        i_rate_req_valid,
  output logic        o_rate_req_ready,
  input  logic        i_tx_idle,
  output logic        o_tx_hold,
  output logic        o_spdif_tx_clk_sel,
  output logic        o_tx_clk_stable,
  output logic        o_busy,
  output logic        o_timeout_err,
  input  logic        i_err_clr
`ifdef SPDIF_CLK_SWITCH_STATS_EN
  ,
  output logic [15:0] o_switch_count
`endif
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LOAD  = TIMER_W'(DRAIN_TIMEOUT - 1);

  spdif_sw_state_e    state_q, state_d;
  logic               req_q, req_d;
  logic               sel_q, sel_d;
  logic               hold_q, stable_q, busy_q, ready_q, err_q, err_d;
  logic               tmr_load, tmr_en, tmr_zero, err_set;
  logic [TIMER_W-1:0] tmr_load_val;

  spdif_sw_timer #(
    .TIMER_W (TIMER_W),
    .RST_VAL (SETTLE_LOAD)
  ) u_timer (
    .i_clk      (i_sys_clk),
    .i_rst      (i_sys_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .i_en       (tmr_en),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rate_req_valid && (i_rate_req != sel_q)) begin
          req_d        = i_rate_req;
          state_d      = ST_DRAIN;
          tmr_load     = 1'b1;
          tmr_load_val = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // a framer reaching idle on the last timeout cycle is a clean drain, not an error
        if (i_tx_idle) begin
          state_d = ST_SWITCH;
        end else if (tmr_zero) begin
          err_set = 1'b1;
          state_d = ST_SWITCH;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SWITCH: begin
        state_d      = ST_SETTLE;
        tmr_load     = 1'b1;
        tmr_load_val = SETTLE_LOAD;
      end
      default: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
    endcase
  end

  // outputs are registered from the next state so they line up with the state register
  assign sel_d = (state_d == ST_SWITCH) ? req_q : sel_q;
  assign err_d = err_set ? 1'b1 : (i_err_clr ? 1'b0 : err_q);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q  <= ST_SETTLE;
      req_q    <= RATE_44K1;
      sel_q    <= RATE_44K1;
      hold_q   <= 1'b1;
      stable_q <= 1'b0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      hold_q   <= (state_d != ST_IDLE);
      stable_q <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
      ready_q  <= (state_d == ST_IDLE);
      err_q    <= err_d;
    end
  end

  assign o_rate_req_ready   = ready_q;
  assign o_tx_hold          = hold_q;
  assign o_spdif_tx_clk_sel = sel_q;
  assign o_tx_clk_stable    = stable_q;
  assign o_busy             = busy_q;
  assign o_timeout_err      = err_q;

`ifdef SPDIF_CLK_SWITCH_STATS_EN
  logic [15:0] sw_cnt_q;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      sw_cnt_q <= '0;
    end else if ((state_q == ST_SWITCH) && (sw_cnt_q != 16'hFFFF)) begin
      sw_cnt_q <= sw_cnt_q + 16'd1;
    end
  end

  assign o_switch_count = sw_cnt_q;
`endif

endmodule

// File: tb/tb_spdif_tx_clk_switch.sv
// tb/tb_spdif_tx_clk_switch.sv - directed table-driven bench for spdif_tx_clk_switch (SETTLE=16, DRAIN=32)
module tb_spdif_tx_clk_switch;

  localparam int SETTLE = 16;
  localparam int DRAIN  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, valid = 1'b0, idle = 1'b1, clr = 1'b0;
  logic ready, hold, sel, stable, busy, err;
  logic [5:0] outs;
`ifdef SPDIF_CLK_SWITCH_STATS_EN
  logic [15:0] sw_count;
`endif

  always #5 clk = ~clk;

  spdif_tx_clk_switch #(
    .SETTLE_CYCLES (SETTLE),
    .DRAIN_TIMEOUT (DRAIN),
    .TIMER_W       (16)
  ) dut (
    .i_sys_clk          (clk),
    .i_sys_rst          (rst),
    .i_rate_req         (req),
    .i_rate_req_valid   (valid),
    .o_rate_req_ready   (ready),
    .i_tx_idle          (idle),
    .o_tx_hold          (hold),
    .o_spdif_tx_clk_sel (sel),
    .o_tx_clk_stable    (stable),
    .o_busy             (busy),
    .o_timeout_err      (err),
    .i_err_clr          (clr)
`ifdef SPDIF_CLK_SWITCH_STATS_EN
    ,
    .o_switch_count     (sw_count)
`endif
  );

  assign outs = {ready, hold, sel, stable, busy, err};

  typedef struct {
    string      name;
    int         cycles;
    logic       req;
    logic       valid;
    logic       idle;
    logic       clr;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // {ready, hold, sel, stable, busy, err}
  function automatic logic [5:0] idl(input logic s, input logic e);
    return {1'b1, 1'b0, s, 1'b1, 1'b0, e};
  endfunction

  function automatic logic [5:0] bsy(input logic s, input logic e);
    return {1'b0, 1'b1, s, 1'b0, 1'b1, e};
  endfunction

  task automatic add(input string nm, input int cyc, input logic r, input logic v,
                     input logic i, input logic c, input logic [5:0] e);
    vec_t t;
    t.name = nm; t.cycles = cyc; t.req = r; t.valid = v; t.idle = i; t.clr = c; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (ready,hold,sel,stable,busy,err)", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic settle_after_reset(input string nm);
    for (int i = 1; i < SETTLE; i++) begin
      step();
      chk({nm, "_settling"}, outs, bsy(1'b0, 1'b0));
    end
    step();
    chk({nm, "_released"}, outs, idl(1'b0, 1'b0));
  endtask

  task automatic do_switch(input logic r);
    req = r; valid = 1'b1; idle = 1'b1; clr = 1'b0;
    step();
    valid = 1'b0;
    for (int i = 0; i < SETTLE + 2; i++) step();
    chk("switch_seq", outs, idl(r, 1'b0));
  endtask

  initial begin
    // A: 0->1 with TX idle
    add("A_accept",      1,  1, 1, 1, 0, bsy(0, 0));
    add("A_sel_plus2",   1,  1, 0, 1, 0, bsy(1, 0));
    add("A_settle_end",  16, 1, 0, 1, 0, bsy(1, 0));
    add("A_stable_p19",  1,  1, 0, 1, 0, idl(1, 0));
    // B: request equal to current select
    add("B_same_rate",   1,  1, 1, 1, 0, idl(1, 0));
    add("B_after",       1,  1, 0, 1, 0, idl(1, 0));
    // C: forced drain timeout, sticky error, clear
    add("C_accept",      1,  0, 1, 0, 0, bsy(1, 0));
    add("C_drain",       31, 0, 0, 0, 0, bsy(1, 0));
    add("C_forced",      1,  0, 0, 0, 0, bsy(0, 1));
    add("C_settled",     17, 0, 0, 0, 0, idl(0, 1));
    add("C_err_sticky",  3,  0, 0, 1, 0, idl(0, 1));
    add("C_err_clr",     1,  0, 0, 1, 1, idl(0, 0));
    // D: idle arrives on the last timeout cycle
    add("D_accept",      1,  1, 1, 0, 0, bsy(0, 0));
    add("D_drain",       31, 1, 0, 0, 0, bsy(0, 0));
    add("D_idle_wins",   1,  1, 0, 1, 0, bsy(1, 0));
    add("D_settled",     17, 1, 0, 1, 0, idl(1, 0));
    // E: clear coincident with timeout
    add("E_accept",      1,  0, 1, 0, 0, bsy(1, 0));
    add("E_drain",       31, 0, 0, 0, 0, bsy(1, 0));
    add("E_set_wins",    1,  0, 0, 0, 1, bsy(0, 1));
    add("E_settled",     17, 0, 0, 0, 0, idl(0, 1));
    add("E_clr",         1,  0, 0, 0, 1, idl(0, 0));
    // F: request pulsed during SETTLE is ignored
    add("F_accept",      1,  1, 1, 1, 0, bsy(0, 0));
    add("F_switch",      1,  1, 0, 1, 0, bsy(1, 0));
    add("F_settle",      3,  1, 0, 1, 0, bsy(1, 0));
    add("F_pulse",       1,  0, 1, 1, 0, bsy(1, 0));
    add("F_settle_end",  12, 0, 0, 1, 0, bsy(1, 0));
    add("F_done",        1,  0, 0, 1, 0, idl(1, 0));

    step();
    step();
    chk("reset_state", outs, bsy(1'b0, 1'b0));
    rst = 1'b0;
    settle_after_reset("reset_release");

    foreach (tbl[k]) begin
      req = tbl[k].req; valid = tbl[k].valid; idle = tbl[k].idle; clr = tbl[k].clr;
      for (int c = 0; c < tbl[k].cycles; c++) step();
      chk(tbl[k].name, outs, tbl[k].exp);
    end
    valid = 1'b0; clr = 1'b0;

    // asynchronous reset in the middle of DRAIN
    req = 1'b0; valid = 1'b1; idle = 1'b0;
    step();
    valid = 1'b0;
    chk("R_in_drain", outs, bsy(1'b1, 1'b0));
    rst = 1'b1;
    #1;
    chk("R_async", outs, bsy(1'b0, 1'b0));
    step();
    rst = 1'b0;
    idle = 1'b1;
    settle_after_reset("R_rerun");

    do_switch(1'b1);
    do_switch(1'b0);
    do_switch(1'b1);
`ifdef SPDIF_CLK_SWITCH_STATS_EN
    chk16("switch_count", sw_count, 16'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
